// File: rtl/id_exe_stage_pkg.sv
// Shared constants and types for the ID/EX stage.
// ALU operation codes, forwarding selects and control bundle.
package id_exe_stage_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [3:0] EXE_AND          = 4'd0;
    localparam logic [3:0] EXE_OR           = 4'd1;
    localparam logic [3:0] EXE_ADD          = 4'd2;
    localparam logic [3:0] EXE_SUB          = 4'd3;
    localparam logic [3:0] EXE_SLT          = 4'd4;
    localparam logic [3:0] EXE_SLL          = 4'd5;
    localparam logic [3:0] EXE_SRL          = 4'd6;
    localparam logic [3:0] EXE_SRA          = 4'd7;
    localparam logic [3:0] EXE_XOR          = 4'd8;
    localparam logic [3:0] EXE_NOR          = 4'd9;
    localparam logic [3:0] EXE_LUI          = 4'd10;
    localparam logic [3:0] EXE_NO_OPERATION = 4'd15;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic alusrc;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ctrl_t;

    // A writer matches a source only if it really writes a nonzero reg.
    function automatic logic wr_hit(
        input logic       we,
        input logic [4:0] dest,
        input logic [4:0] src
    );
        return we && (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/id_exe_stage_forward_unit.sv
// Operand forwarding for one EX source: MEM result beats WB result,
// which beats the value captured from the register file.
module id_exe_stage_forward_unit
    import id_exe_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [4:0]       exe_src,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_dest,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_dest,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] fwd
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (wr_hit(mem_regwrite, mem_dest, exe_src)) begin
            sel = FWD_MEM;
        end else if (wr_hit(wb_regwrite, wb_dest, exe_src)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        fwd = reg_data;
        unique case (sel)
            FWD_MEM: fwd = mem_result;
            FWD_WB:  fwd = wb_result;
            default: fwd = reg_data;
        endcase
    end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with forwarding, WB capture bypass,
// load-use stall/bubble and branch flush.
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_dest,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [3:0]       id_alucontrol,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_dest,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_dest,
    input  logic [WIDTH-1:0] wb_result,
    output logic             stall,
    output logic             exe_valid,
    output logic [WIDTH-1:0] val1,
    output logic [WIDTH-1:0] val2,
    output logic [4:0]       shamt,
    output logic [3:0]       alucontrol_exe,
    output logic [WIDTH-1:0] exe_store_data,
    output logic [4:0]       exe_dest,
    output logic             exe_regwrite,
    output logic             exe_memread,
    output logic             exe_memwrite,
    output logic             exe_memtoreg
);

    typedef struct packed {
        logic             valid;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       dest;
        logic [4:0]       shamt;
        logic [3:0]       aluc;
        ctrl_t            ctrl;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;
    ex_t bubble;

    logic             hazard;
    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    always_comb begin
        bubble      = '0;
        bubble.aluc = EXE_NO_OPERATION;
    end

    // Only a load still sitting in EX can create a load-use hazard.
    always_comb begin
        hazard = 1'b0;
        if (ex_q.valid && ex_q.ctrl.memread && ex_q.dest != 5'd0) begin
            hazard = (id_use_rs && ex_q.dest == id_rs)
                  || (id_use_rt && ex_q.dest == id_rt);
        end
    end

    assign stall = !flush && id_valid && hazard;

    always_comb begin
        ex_d = bubble;
        if (!flush && !stall && id_valid) begin
            ex_d.valid         = 1'b1;
            ex_d.rs            = id_rs;
            ex_d.rt            = id_rt;
            ex_d.dest          = id_dest;
            ex_d.shamt         = id_shamt;
            ex_d.aluc          = id_alucontrol;
            ex_d.ctrl.alusrc   = id_alusrc;
            ex_d.ctrl.regwrite = id_regwrite;
            ex_d.ctrl.memread  = id_memread;
            ex_d.ctrl.memwrite = id_memwrite;
            ex_d.ctrl.memtoreg = id_memtoreg;
            ex_d.imm           = id_imm;
            ex_d.rs_data       = wr_hit(wb_regwrite, wb_dest, id_rs)
                               ? wb_result : id_rs_data;
            ex_d.rt_data       = wr_hit(wb_regwrite, wb_dest, id_rt)
                               ? wb_result : id_rt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    id_exe_stage_forward_unit #(.WIDTH(WIDTH)) u_fwd_rs (
        .exe_src     (ex_q.rs),
        .reg_data    (ex_q.rs_data),
        .mem_regwrite(mem_regwrite),
        .mem_dest    (mem_dest),
        .mem_result  (mem_result),
        .wb_regwrite (wb_regwrite),
        .wb_dest     (wb_dest),
        .wb_result   (wb_result),
        .fwd         (fwd_rs)
    );

    id_exe_stage_forward_unit #(.WIDTH(WIDTH)) u_fwd_rt (
        .exe_src     (ex_q.rt),
        .reg_data    (ex_q.rt_data),
        .mem_regwrite(mem_regwrite),
        .mem_dest    (mem_dest),
        .mem_result  (mem_result),
        .wb_regwrite (wb_regwrite),
        .wb_dest     (wb_dest),
        .wb_result   (wb_result),
        .fwd         (fwd_rt)
    );

    assign exe_valid      = ex_q.valid;
    assign val1           = fwd_rs;
    assign val2           = ex_q.ctrl.alusrc ? ex_q.imm : fwd_rt;
    assign exe_store_data = fwd_rt;
    assign shamt          = ex_q.shamt;
    assign alucontrol_exe = ex_q.aluc;
    assign exe_dest       = ex_q.dest;
    assign exe_regwrite   = ex_q.ctrl.regwrite;
    assign exe_memread    = ex_q.ctrl.memread;
    assign exe_memwrite   = ex_q.ctrl.memwrite;
    assign exe_memtoreg   = ex_q.ctrl.memtoreg;

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage with a behavioural reference model.
// The model is compared against every DUT output on each falling edge.
module tb_id_exe_stage;
    import id_exe_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest, id_shamt;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]  id_alucontrol;
    logic        id_alusrc, id_regwrite, id_memread;
    logic        id_memwrite, id_memtoreg;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_dest, wb_dest;
    logic [31:0] mem_result, wb_result;
    logic        stall, exe_valid;
    logic [31:0] val1, val2, exe_store_data;
    logic [4:0]  shamt, exe_dest;
    logic [3:0]  alucontrol_exe;
    logic        exe_regwrite, exe_memread;
    logic        exe_memwrite, exe_memtoreg;

    int tests = 0;
    int fails = 0;

    id_exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alucontrol(id_alucontrol),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_dest(mem_dest),
        .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
        .wb_result(wb_result),
        .stall(stall), .exe_valid(exe_valid),
        .val1(val1), .val2(val2), .shamt(shamt),
        .alucontrol_exe(alucontrol_exe),
        .exe_store_data(exe_store_data), .exe_dest(exe_dest),
        .exe_regwrite(exe_regwrite), .exe_memread(exe_memread),
        .exe_memwrite(exe_memwrite), .exe_memtoreg(exe_memtoreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what instruction EX holds, in plain terms.
    logic        model_ok = 1'b0;
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_dest, m_shamt;
    logic [3:0]  m_aluc;
    logic        m_alusrc, m_rw, m_mr, m_mw, m_mt;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic        m_st;

    function automatic logic writes(logic we, logic [4:0] d,
                                    logic [4:0] r);
        return we && d != 0 && d == r;
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] r,
                                        logic [31:0] d);
        if (writes(mem_regwrite, mem_dest, r)) return mem_result;
        if (writes(wb_regwrite, wb_dest, r)) return wb_result;
        return d;
    endfunction

    function automatic logic exp_stall();
        logic dep;
        dep = (id_use_rs && id_rs == m_dest)
           || (id_use_rt && id_rt == m_dest);
        return !flush && id_valid && m_valid && m_mr
            && m_dest != 0 && dep;
    endfunction

    always @(posedge clk) begin
        m_st = exp_stall();
        if (rst) model_ok = 1'b1;
        if (rst || flush || m_st || !id_valid) begin
            m_valid = 0; m_rs = 0; m_rt = 0; m_dest = 0;
            m_shamt = 0; m_aluc = EXE_NO_OPERATION;
            m_alusrc = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mt = 0;
            m_rsd = 0; m_rtd = 0; m_imm = 0;
        end else begin
            m_valid = 1; m_rs = id_rs; m_rt = id_rt;
            m_dest = id_dest; m_shamt = id_shamt;
            m_aluc = id_alucontrol; m_alusrc = id_alusrc;
            m_rw = id_regwrite; m_mr = id_memread;
            m_mw = id_memwrite; m_mt = id_memtoreg;
            m_imm = id_imm;
            m_rsd = writes(wb_regwrite, wb_dest, id_rs)
                  ? wb_result : id_rs_data;
            m_rtd = writes(wb_regwrite, wb_dest, id_rt)
                  ? wb_result : id_rt_data;
        end
    end

    logic [115:0] act_v, exp_v;

    always @(negedge clk) begin
        if (model_ok) begin
            act_v = {stall, exe_valid, val1, val2, shamt,
                     alucontrol_exe, exe_store_data, exe_dest,
                     exe_regwrite, exe_memread, exe_memwrite,
                     exe_memtoreg};
            exp_v = {exp_stall(), m_valid, fwd(m_rs, m_rsd),
                     m_alusrc ? m_imm : fwd(m_rt, m_rtd),
                     m_shamt, m_aluc, fwd(m_rt, m_rtd), m_dest,
                     m_rw, m_mr, m_mw, m_mt};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL model_cycle t=%0t got=%h want=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
        id_use_rs = 0; id_use_rt = 0; id_shamt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_alucontrol = EXE_NO_OPERATION; id_alusrc = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        id_memtoreg = 0;
    endtask

    task automatic quiet_wb();
        mem_regwrite = 0; mem_dest = 0; mem_result = 0;
        wb_regwrite = 0; wb_dest = 0; wb_result = 0;
    endtask

    task automatic rand_in();
        id_valid = 1'($urandom); flush = 1'($urandom);
        id_rs = 5'($urandom); id_rt = 5'($urandom);
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        id_dest = 5'($urandom); id_shamt = 5'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm = $urandom; id_alucontrol = 4'($urandom);
        id_alusrc = 1'($urandom); id_regwrite = 1'($urandom);
        id_memread = 1'($urandom); id_memwrite = 1'($urandom);
        id_memtoreg = 1'($urandom);
        mem_regwrite = 1'($urandom); mem_dest = 5'($urandom);
        mem_result = $urandom;
        wb_regwrite = 1'($urandom); wb_dest = 5'($urandom);
        wb_result = $urandom;
    endtask

    task automatic load_r5();
        idle_id();
        id_valid = 1; id_rs = 1; id_use_rs = 1;
        id_rs_data = 32'h100; id_imm = 4; id_alusrc = 1;
        id_regwrite = 1; id_memread = 1; id_memtoreg = 1;
        id_dest = 5; id_alucontrol = EXE_ADD;
    endtask

    task automatic add_uses_r5();
        idle_id();
        id_valid = 1; id_rs = 2; id_rt = 5;
        id_use_rs = 1; id_use_rt = 1;
        id_rs_data = 32'h2; id_rt_data = 0;
        id_dest = 6; id_regwrite = 1; id_alucontrol = EXE_ADD;
    endtask

    initial begin
        rst = 1; flush = 0; idle_id(); quiet_wb();
        rand_in(); step();
        rand_in(); step();
        @(negedge clk);
        chk("rst_valid", 32'(exe_valid), 0);
        chk("rst_aluc", 32'(alucontrol_exe), 32'(EXE_NO_OPERATION));
        chk("rst_val1", val1, 0);
        chk("rst_val2", val2, 0);
        chk("rst_stall", 32'(stall), 0);
        rst = 0; flush = 0; idle_id(); quiet_wb();
        step();

        // MEM forward beats WB forward
        id_valid = 1; id_rs = 3; id_rt = 4;
        id_use_rs = 1; id_use_rt = 1;
        id_rs_data = 5; id_rt_data = 7; id_dest = 7;
        id_alucontrol = EXE_ADD; id_regwrite = 1;
        step();
        idle_id();
        mem_regwrite = 1; mem_dest = 3; mem_result = 32'h10;
        @(negedge clk);
        chk("mem_fwd_val1", val1, 32'h10);
        chk("mem_fwd_val2", val2, 7);
        #1;
        wb_regwrite = 1; wb_dest = 3; wb_result = 32'h20;
        #1;
        chk("mem_over_wb", val1, 32'h10);
        mem_regwrite = 0;
        #1;
        chk("wb_fwd_val1", val1, 32'h20);
        quiet_wb();
        step();

        // r0 is never forwarded
        id_valid = 1; id_alucontrol = EXE_ADD;
        step();
        idle_id();
        mem_regwrite = 1; mem_dest = 0; mem_result = 32'hFFFF;
        wb_regwrite = 1; wb_dest = 0; wb_result = 32'h1234;
        @(negedge clk);
        chk("r0_val1", val1, 0);
        chk("r0_val2", val2, 0);
        quiet_wb();
        step();

        // WB result captured while the reader is in ID
        id_valid = 1; id_rs = 9; id_use_rs = 1;
        id_rs_data = 32'h111; id_alucontrol = EXE_OR;
        wb_regwrite = 1; wb_dest = 9; wb_result = 32'h999;
        step();
        idle_id(); quiet_wb();
        @(negedge clk);
        chk("wb_bypass", val1, 32'h999);
        step();

        // Load-use: one stall, one bubble, then WB forward
        load_r5();
        step();
        add_uses_r5();
        @(negedge clk);
        chk("lu_stall", 32'(stall), 1);
        step();
        mem_regwrite = 1; mem_dest = 5; mem_result = 32'h104;
        @(negedge clk);
        chk("lu_bubble", 32'(exe_valid), 0);
        chk("lu_stall_drop", 32'(stall), 0);
        step();
        idle_id(); quiet_wb();
        wb_regwrite = 1; wb_dest = 5; wb_result = 32'hBEEF;
        @(negedge clk);
        chk("lu_val2", val2, 32'hBEEF);
        chk("lu_val1", val1, 32'h2);
        chk("lu_dest", 32'(exe_dest), 6);
        quiet_wb();
        step();

        // Flush overrides stall
        load_r5();
        step();
        add_uses_r5();
        flush = 1;
        @(negedge clk);
        chk("fl_stall", 32'(stall), 0);
        step();
        flush = 0; idle_id();
        @(negedge clk);
        chk("fl_valid", 32'(exe_valid), 0);
        step();

        // Store: immediate to ALU, forwarded rt to memory
        id_valid = 1; id_rs = 1; id_rt = 8;
        id_use_rs = 1; id_use_rt = 1;
        id_rs_data = 32'h40; id_imm = 8; id_alusrc = 1;
        id_memwrite = 1; id_alucontrol = EXE_ADD;
        step();
        idle_id();
        wb_regwrite = 1; wb_dest = 8; wb_result = 32'hABCD;
        @(negedge clk);
        chk("sw_val2", val2, 8);
        chk("sw_store", exe_store_data, 32'hABCD);
        chk("sw_val1", val1, 32'h40);
        chk("sw_memwrite", 32'(exe_memwrite), 1);
        quiet_wb();
        step();

        // Reset in the middle of traffic
        add_uses_r5();
        rst = 1;
        step();
        rst = 0; idle_id();
        @(negedge clk);
        chk("midrst_valid", 32'(exe_valid), 0);
        chk("midrst_aluc", 32'(alucontrol_exe),
            32'(EXE_NO_OPERATION));
        step();
        step();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
